// File: rtl/pipeline_controller.sv
// Pipeline sequencing and hazard control: run/step/drain/halt FSM, load-use stall,
// branch/jump flushes and an enabled-cycle counter.
module pipeline_controller #(
    parameter logic [5:0] HALT_OP      = 6'b111111,
    parameter int         DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    output logic        pipe_enable,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t      state_r;
    logic        mode_r;
    logic        step_q_r;
    logic        halted_r;
    logic [31:0] drain_cnt_r;
    logic [31:0] cycle_count_r;

    logic step_edge_s;
    logic pipe_enable_s;
    logic hazard_s;
    logic halt_now_s;
    logic pc_write_s;
    logic if_id_write_s;
    logic if_id_flush_s;
    logic id_ex_flush_s;

    assign step_edge_s = step & ~step_q_r;
    assign hazard_s    = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Global advance enable; in step mode only the cycle a step edge is seen advances
    always_comb begin
        pipe_enable_s = 1'b0;
        case (state_r)
            RUN:     pipe_enable_s = 1'b1;
            STEP:    pipe_enable_s = step_edge_s;
            DRAIN:   pipe_enable_s = mode_r ? step_edge_s : 1'b1;
            default: pipe_enable_s = 1'b0;
        endcase
    end

    assign halt_now_s = pipe_enable_s && !ex_branch_taken && (id_opcode == HALT_OP)
                        && ((state_r == RUN) || (state_r == STEP));

    // Per-cycle enables and flushes; branch wins over load-use, load-use over jump
    always_comb begin
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        if (pipe_enable_s) begin
            if (ex_branch_taken) begin
                pc_write_s    = 1'b1;
                if_id_write_s = 1'b1;
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
            end else if (hazard_s) begin
                id_ex_flush_s = 1'b1;
            end else if (id_jump) begin
                pc_write_s    = 1'b1;
                if_id_write_s = 1'b1;
                if_id_flush_s = 1'b1;
            end else begin
                pc_write_s    = 1'b1;
                if_id_write_s = 1'b1;
            end
            // Once HALT is in ID nothing new is fetched unless a branch abandons the halt
            if (halt_now_s || ((state_r == DRAIN) && !ex_branch_taken)) begin
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
            end else begin
                pc_write_s    = pc_write_s;
                if_id_write_s = if_id_write_s;
            end
        end else begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
        end
    end

    // FSM, step edge history, drain counter and saturating cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            mode_r        <= 1'b0;
            step_q_r      <= 1'b0;
            halted_r      <= 1'b0;
            drain_cnt_r   <= 32'd0;
            cycle_count_r <= 32'd0;
        end else begin
            step_q_r <= step;
            if (pipe_enable_s && (cycle_count_r != 32'hFFFF_FFFF)) begin
                cycle_count_r <= cycle_count_r + 32'd1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r  <= step_mode;
                        state_r <= step_mode ? STEP : RUN;
                    end
                end
                RUN, STEP: begin
                    if (halt_now_s) begin
                        state_r     <= DRAIN;
                        drain_cnt_r <= 32'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (pipe_enable_s) begin
                        if (ex_branch_taken) begin
                            state_r <= mode_r ? STEP : RUN;
                        end else if (drain_cnt_r <= 32'd1) begin
                            state_r  <= HALTED;
                            halted_r <= 1'b1;
                        end else begin
                            drain_cnt_r <= drain_cnt_r - 32'd1;
                        end
                    end
                end
                HALTED:  state_r <= HALTED;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign pipe_enable = pipe_enable_s;
    assign pc_write    = pc_write_s;
    assign if_id_write = if_id_write_s;
    assign if_id_flush = if_id_flush_s;
    assign id_ex_flush = id_ex_flush_s;
    assign halted      = halted_r;
    assign state       = state_r;
    assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus random
// stimulus, compared every negedge against a behavioural model.
module tb_pipeline_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        id_jump;
    logic        pipe_enable;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipeline_controller dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
        .pipe_enable(pipe_enable), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halted(halted),
        .state(state), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    endtask

    // Behavioural model: phase per the specified state numbering
    int          m_phase = 0;
    bit          m_step_mode = 0;
    bit          m_prev_step = 0;
    int          m_left = 0;
    longint      m_count = 0;

    always @(negedge clk) begin
        bit edge_seen, en, hz, halting, br;
        bit e_pc, e_ifw, e_ifl, e_idf;
        if (!reset) begin
            m_phase = 0; m_step_mode = 0; m_prev_step = 0; m_left = 0; m_count = 0;
            en = 0; e_pc = 0; e_ifw = 0; e_ifl = 0; e_idf = 0;
        end else begin
            br        = ex_branch_taken;
            edge_seen = step && !m_prev_step;
            en = (m_phase == 1) || (m_phase == 2 && edge_seen) ||
                 (m_phase == 3 && (m_step_mode ? edge_seen : 1'b1));
            hz = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
            halting = !br && ((m_phase == 3) ||
                              ((m_phase == 1 || m_phase == 2) && id_opcode == 6'b111111));
            e_ifl = en && (br || (id_jump && !hz));
            e_idf = en && (br || hz);
            e_pc  = en && (br || !hz) && !halting;
            e_ifw = e_pc;
        end
        check("pipe_enable", 32'(pipe_enable), 32'(en));
        check("pc_write",    32'(pc_write),    32'(e_pc));
        check("if_id_write", 32'(if_id_write), 32'(e_ifw));
        check("if_id_flush", 32'(if_id_flush), 32'(e_ifl));
        check("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
        check("halted",      32'(halted),      32'(m_phase == 4));
        check("state",       32'(state),       32'(m_phase));
        check("cycle_count", cycle_count,      32'(m_count));
        if (reset) begin
            // predict the effect of the coming rising edge
            if (en && m_count != 64'hFFFF_FFFF) m_count++;
            case (m_phase)
                0: if (start) begin m_step_mode = step_mode; m_phase = step_mode ? 2 : 1; end
                1, 2: if (en && !ex_branch_taken && id_opcode == 6'b111111) begin
                    m_phase = 3; m_left = 3;
                end
                3: if (en) begin
                    if (ex_branch_taken) m_phase = m_step_mode ? 2 : 1;
                    else if (m_left == 1) m_phase = 4;
                    else m_left--;
                end
                default: ;
            endcase
            m_prev_step = step;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; step_mode = 0; step = 0; id_opcode = 6'd0; id_rs = 5'd1; id_rt = 5'd2;
        ex_mem_read = 0; ex_rt = 5'd0; ex_branch_taken = 0; id_jump = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        clear_inputs();
        tick(); tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_count", cycle_count, 32'd0);
        check("reset_pe", 32'(pipe_enable), 32'd0);
        reset = 1;
        tick();
    endtask

    initial begin
        int c0;
        reset = 0;
        clear_inputs();
        do_reset();

        // free run for 10 cycles
        start = 1; tick(); start = 0;
        repeat (10) tick();
        check("freerun_count", cycle_count, 32'd10);
        check("freerun_pe", 32'(pipe_enable), 32'd1);

        // load-use stall and its ex_rt==0 exception
        ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; #1;
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_if_id_write", 32'(if_id_write), 32'd0);
        check("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        ex_rt = 5'd0; id_rs = 5'd0; #1;
        check("lu_rt0_pc_write", 32'(pc_write), 32'd1);
        ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1; #1;
        check("br_lu_if_id_flush", 32'(if_id_flush), 32'd1);
        check("br_lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check("br_lu_pc_write", 32'(pc_write), 32'd1);
        tick();
        clear_inputs();
        tick();

        // halt then three drain cycles
        id_opcode = 6'b111111; #1;
        c0 = cycle_count;
        tick(); id_opcode = 6'd0;
        check("drain_state", 32'(state), 32'd3);
        repeat (3) tick();
        check("halt_state", 32'(state), 32'd4);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_count", cycle_count, 32'(c0 + 4));
        start = 1; step = 1; tick(); step = 0; tick(); start = 0; tick();
        check("halt_frozen", cycle_count, 32'(c0 + 4));

        // step mode: one long pulse then two short ones
        do_reset();
        step_mode = 1; start = 1; tick(); start = 0;
        step = 1; repeat (5) tick(); step = 0; tick();
        repeat (2) begin step = 1; tick(); step = 0; tick(); end
        check("step_count", cycle_count, 32'd3);
        check("step_state", 32'(state), 32'd2);

        // branch in the 2nd drain cycle resumes RUN, then reset mid-run
        do_reset();
        start = 1; tick(); start = 0; tick();
        id_opcode = 6'b111111; tick(); id_opcode = 6'd0;
        tick();
        ex_branch_taken = 1; #1;
        check("drain_br_flush", 32'(if_id_flush), 32'd1);
        tick(); ex_branch_taken = 0;
        check("drain_br_state", 32'(state), 32'd1);
        tick();
        reset = 0; #1;
        check("async_rst_pe", 32'(pipe_enable), 32'd0);
        check("async_rst_pc", 32'(pc_write), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_count", cycle_count, 32'd0);
        tick();
        reset = 1; tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(99) >= 2);
            start           = ($urandom_range(99) < 20);
            step_mode       = $urandom_range(1);
            if ($urandom_range(99) < 35) step = ~step;
            id_opcode       = ($urandom_range(99) < 4) ? 6'b111111 : 6'($urandom_range(62));
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            ex_rt           = 5'($urandom_range(3));
            ex_mem_read     = $urandom_range(1);
            ex_branch_taken = ($urandom_range(99) < 10);
            id_jump         = ($urandom_range(99) < 15);
            tick();
        end
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
